// File: rtl/seq_pattern_tx.sv
// Purpose : serial pattern transmitter; shifts a captured pattern MSB-first onto `out`,
//           repeating it `repeat_cnt` times (optionally with idle gaps between frames).
// Latency : start accepted at edge k -> first bit valid from edge k+1; done the cycle after the last bit.
// Backpr. : none on the serial side; `start` is only sampled in IDLE, otherwise ignored.
//
// Ports:
//   clk        rising-edge clock
//   areset_n   asynchronous active-low reset; aborts a transfer without a done pulse
//   start      transfer request (sampled only in IDLE)
//   pattern    W-bit pattern, captured on accepted start
//   len        bits per frame (0 or >W clamps to W), captured on accepted start
//   repeat_cnt frames to send (0 clamps to 1), captured on accepted start
//   out        serial bit
//   valid      high while out carries a pattern bit
//   busy       high from accept until done
//   frame_end  high during the last bit of each frame
//   done       one-cycle pulse after the final frame
//
// Build option: define SEQ_TX_GAP_EN to insert GAP_LEN idle cycles between frames.
module seq_pattern_tx #(
  parameter int W     = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
`ifdef SEQ_TX_GAP_EN
  , parameter int GAP_LEN = 2
`endif
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10,
    S_GAP   = 2'b11
  } state_t;

  localparam logic [LEN_W-1:0] W_L = LEN_W'(W);

  state_t           state;
  logic [W-1:0]     pattern_q;
  logic [W-1:0]     sr;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] rep_q;
  logic [LEN_W-1:0] bitcnt;
  logic [CNT_W-1:0] frame;

`ifdef SEQ_TX_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gapcnt;
`endif

  logic [LEN_W-1:0] len_c;
  logic [CNT_W-1:0] rep_c;
  logic             last_bit;
  logic             last_frame;

  // Clamp the requested frame geometry so the counters can never wrap.
  always_comb begin
    len_c = ((len == '0) || (len > W_L)) ? W_L : len;
    rep_c = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
  end

  assign last_bit   = (bitcnt == len_q - LEN_W'(1));
  assign last_frame = (frame == rep_q - CNT_W'(1));

  // Left-align the active len bits so the shift register MSB is always the next bit,
  // equivalent to indexing pattern_q[len_q-1-bitcnt].
  function automatic logic [W-1:0] align(input logic [W-1:0] p, input logic [LEN_W-1:0] l);
    return p << (W_L - l);
  endfunction

  // Outputs are registered from the current state, so they trail the state by one edge:
  // SHIFT entered at edge k shows its first bit after edge k+1.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= S_IDLE;
      pattern_q <= '0;
      sr        <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      bitcnt    <= '0;
      frame     <= '0;
      out       <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gapcnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          out       <= 1'b0;
          valid     <= 1'b0;
          busy      <= 1'b0;
          frame_end <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            pattern_q <= pattern;
            sr        <= align(pattern, len_c);
            len_q     <= len_c;
            rep_q     <= rep_c;
            bitcnt    <= '0;
            frame     <= '0;
            state     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          out       <= sr[W-1];
          valid     <= 1'b1;
          busy      <= 1'b1;
          frame_end <= last_bit;
          done      <= 1'b0;
          sr        <= sr << 1;
          bitcnt    <= bitcnt + LEN_W'(1);
          if (last_bit) begin
            bitcnt <= '0;
            if (last_frame) begin
              state <= S_DONE;
            end else begin
              frame <= frame + CNT_W'(1);
              sr    <= align(pattern_q, len_q);
`ifdef SEQ_TX_GAP_EN
              // A zero-length gap degenerates to back-to-back frames.
              if (GAP_LEN > 0) begin
                gapcnt <= '0;
                state  <= S_GAP;
              end
`endif
            end
          end
        end

`ifdef SEQ_TX_GAP_EN
        S_GAP: begin
          out       <= 1'b0;
          valid     <= 1'b0;
          busy      <= 1'b1;
          frame_end <= 1'b0;
          done      <= 1'b0;
          gapcnt    <= gapcnt + GAP_W'(1);
          if (gapcnt == GAP_LAST) begin
            state <= S_SHIFT;
          end
        end
`endif

        S_DONE: begin
          out       <= 1'b0;
          valid     <= 1'b0;
          busy      <= 1'b0;
          frame_end <= 1'b0;
          done      <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          // Unreachable encodings (including GAP when it is not built) recover to IDLE.
          out       <= 1'b0;
          valid     <= 1'b0;
          busy      <= 1'b0;
          frame_end <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: randomized and directed transfers, expected bit stream and
// per-transfer busy length derived from the frame rules, checked by an independent monitor.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_cnt;
  logic       out, valid, busy, frame_end, done;

  seq_pattern_tx dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .out        (out),
    .valid      (valid),
    .busy       (busy),
    .frame_end  (frame_end),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic fe;
  } bit_t;

  bit_t bq[$];   // expected serial bits, in order
  int   cq[$];   // expected busy cycles per transfer

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every frame is the low L bits of the pattern sent MSB-first.
  task automatic push_expect(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    int L, R;
    bit_t e;
    L = (l == 0 || l > W) ? W : int'(l);
    R = (r == 0) ? 1 : int'(r);
    for (int f = 0; f < R; f++) begin
      for (int i = 0; i < L; i++) begin
        e.b  = p[L-1-i];
        e.fe = (i == L - 1);
        bq.push_back(e);
      end
    end
    cq.push_back(R * L + (R - 1) * GAP);
  endtask

  task automatic issue(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    pattern    = p;
    len        = l;
    repeat_cnt = r;
    start      = 1'b1;
    push_expect(p, l, r);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    issue(p, l, r);
    @(negedge clk);
    chk("valid_before_first_bit", valid, 0);
    @(negedge clk);
    chk("valid_first_bit", valid, 1);
    chk("busy_first_bit", busy, 1);
    wait_done();
  endtask

  // Monitor: compares every valid bit and every transfer's busy length against the queues.
  int  run = 0;
  logic prev_done = 1'b0;
  initial begin
    bit_t e;
    forever begin
      @(negedge clk);
      if (!areset_n) begin
        run = 0;
        prev_done = 1'b0;
      end else begin
        if (valid) begin
          if (bq.size() == 0) begin
            chk("unexpected_bit", 1, 0);
          end else begin
            e = bq.pop_front();
            chk("out_bit", out, e.b);
            chk("frame_end", frame_end, e.fe);
          end
          chk("valid_without_busy", busy, 1);
        end else begin
          chk("idle_out_frame_end", {out, frame_end}, 0);
        end
        if (busy) run++;
        if (done) begin
          chk("busy_during_done", busy, 0);
          chk("done_width", prev_done, 0);
          if (cq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("busy_cycles", run, cq.pop_front());
          end
          run = 0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    areset_n   = 1'b0;
    start      = 1'b0;
    pattern    = '0;
    len        = '0;
    repeat_cnt = '0;
    #1;
    chk("reset_out", out, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_end", frame_end, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    areset_n = 1'b1;

    // Single short frame: 101 from pattern 05, len 3.
    send(8'h05, 4'd3, 4'd1);
    // Repeated full frame (with or without gap).
    send(8'hA5, 4'd8, 4'd2);
    // Clamping: len 0 / repeat 0 -> one 8-bit frame; len 12 -> 8 bits.
    send(8'h3C, 4'd0, 4'd0);
    send(8'hC3, 4'd12, 4'd1);
    send(8'h81, 4'd1, 4'd3);

    // Start pulsed mid-transfer with different inputs must not disturb the stream.
    issue(8'hA5, 4'd8, 4'd3);
    repeat (4) @(negedge clk);
    pattern    = 8'hFF;
    len        = 4'd2;
    repeat_cnt = 4'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start held high: second transfer accepted the edge after done.
    @(negedge clk);
    pattern    = 8'h6B;
    len        = 4'd5;
    repeat_cnt = 4'd2;
    start      = 1'b1;
    push_expect(8'h6B, 4'd5, 4'd2);
    push_expect(8'h6B, 4'd5, 4'd2);
    wait_done();
    wait_done();
    start = 1'b0;

    // Asynchronous reset mid-frame aborts the transfer with no done pulse.
    issue(8'hF0, 4'd8, 4'd4);
    repeat (5) @(posedge clk);
    #2 areset_n = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_end", frame_end, 0);
    chk("abort_done", done, 0);
    bq.delete();
    cq.delete();
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    send(8'h5A, 4'd6, 4'd2);

    // Randomized transfers.
    for (int n = 0; n < 30; n++) begin
      send(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)));
    end

    repeat (4) @(negedge clk);
    chk("bits_left_over", bq.size(), 0);
    chk("transfers_left_over", cq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter. It shifts a programmable bit pattern, MSB-first, onto a single-bit line and repeats it a programmable number of times. It is the sending end of the FSM sequence-detection path: the stimulus and link source that drives single-bit `in` ports of the team's Moore/Mealy sequence detectors. All outputs are registered (Moore style) and depend only on state and datapath registers.

## Interface
- `W`, 8: pattern register width in bits.
- `LEN_W`, 4: width of `len`; must satisfy 2^LEN_W > W.
- `CNT_W`, 4: width of `repeat` and of the internal frame counter.
- `GAP_LEN`, 2: number of idle cycles between frames; used only when `SEQ_TX_GAP_EN` is defined.

- `clk`  in  1  rising-edge clock.
- `areset_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  W  bits to send; captured on accepted `start`.
- `len`  in  LEN_W  bits per frame; captured on accepted `start`.
- `repeat`  in  CNT_W  frames to send; captured on accepted `start`.
- `out`  out  1  serial bit.
- `valid`  out  1  high while `out` carries a pattern bit.
- `busy`  out  1  high from accept until `done`.
- `frame_end`  out  1  high during the last bit of each frame.
- `done`  out  1  one-cycle pulse after the final frame.

## Operation
- States: IDLE, SHIFT, GAP (present only with `SEQ_TX_GAP_EN`), DONE.
- IDLE: outputs 0. If `start`=1 at an edge, the block:
  - captures `pattern` into a shift register;
  - sets `len_q` = (`len`==0 or `len`>W) ? W : `len`;
  - sets `rep_q` = (`repeat`==0) ? 1 : `repeat`;
  - goes to SHIFT.
- SHIFT:
  - `out` = `pattern_q[len_q-1-bitcnt]`, `valid`=1, `busy`=1.
  - `bitcnt` increments each cycle.
  - `frame_end`=1 when `bitcnt`==`len_q`-1.
- At the frame's last bit:
  - If frames remain: go to GAP, or with no gap compiled in, restart SHIFT with `bitcnt`=0 so frames run back-to-back.
  - If this was the last frame: go to DONE.
- GAP: `out`=0, `valid`=0, `busy`=1 for exactly `GAP_LEN` cycles, then SHIFT.
- DONE: `done`=1, `busy`=0, `valid`=0, `out`=0 for one cycle, then IDLE.
- `start` is ignored in SHIFT, GAP and DONE. Captured values never change mid-transfer.
- Illegal state encodings return to IDLE on the next edge.
- `areset_n` low at any time:
  - immediately forces IDLE and all outputs to 0;
  - clears counters;
  - aborts any transfer in progress with no `done` pulse.

## Timing
- Reset values: `out`=0, `valid`=0, `busy`=0, `frame_end`=0, `done`=0.
- Latency: if `start` is accepted at edge k, the first bit is on `out` with `valid`=1 from edge k+1.
- One bit per cycle. A frame occupies `len_q` consecutive cycles.
- Total busy cycles = `rep_q`*`len_q` + (`rep_q`-1)*gap, where gap = `GAP_LEN` if `SEQ_TX_GAP_EN` is defined, else 0.
- `done` is asserted in the cycle after the last bit. IDLE is reached one cycle later, so the earliest next accepted `start` is 2 cycles after the last bit's edge.
- `start` held high continuously: a new transfer is accepted on the first edge in IDLE.
- Counters: `bitcnt` is LEN_W bits and `frame` is CNT_W bits. Neither wraps, because clamping bounds both.

## Configuration
- `SEQ_TX_GAP_EN` defined:
  - GAP state is present;
  - `GAP_LEN` idle (`valid`=0, `out`=0) cycles are inserted between frames;
  - `GAP_LEN`=0 behaves like undefined.
- `SEQ_TX_GAP_EN` undefined:
  - GAP state and its counter are not built;
  - frames are contiguous, with `valid` staying high across frame boundaries.

## Test plan
- Reset check: drive `areset_n`=0 mid-frame -> all outputs 0 asynchronously. After release the block is in IDLE; the next `start` is accepted normally.
- Single frame: `pattern`=8'h05, `len`=3, `repeat`=1, `start` at edge k -> `out`=1,0,1 at k+1..k+3, `frame_end` at k+3, `done` at k+4, `busy` 0 at k+4.
- Repeat with gap: `SEQ_TX_GAP_EN`, `GAP_LEN`=2, `pattern`=8'hA5, `len`=8, `repeat`=2 -> bits 10100101, two idle cycles, 10100101, then `done`; 18 busy cycles.
- Repeat without gap: macro undefined, same stimulus -> 16 contiguous valid bits, then `done`.
- Clamping: `len`=0 and `repeat`=0 -> exactly one 8-bit frame. `len`=12 with W=8 -> 8 bits.
- Ignored start: pulse `start` with `pattern`=8'hFF during SHIFT -> the stream is unchanged and no extra frame is sent.
